byte_serial_mult_ctrl: RTL and testbench

BYTE_SERIAL_MULT_CTRL -- requirements
Module: byte_serial_mult_ctrl

---
 rtl/byte_serial_mult_ctrl.sv | 122 ++++++++++++
 tb/tb_byte_serial_mult_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_mult_ctrl.sv
// Byte-serial unsigned multiplier: p = a * b, consuming one byte of b per cycle, MSB byte first.
// Define EARLY_TERM_EN to skip leading zero bytes of b (b == 0 completes at the accept edge).
module byte_serial_mult_ctrl #(
    parameter int BYTES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*BYTES-1:0]     a,
    input  logic [8*BYTES-1:0]     b,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [16*BYTES-1:0]    p
);

    localparam int N  = 8 * BYTES;
    localparam int AW = 2 * N;
    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    a_lat;
    logic [N-1:0]    b_lat;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic [7:0]      b_byte;
    logic [N+7:0]    pp;
    logic [AW-1:0]   acc_next;

    always_comb begin
        b_byte = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (cnt == CW'(i)) b_byte = b_lat[8*i +: 8];
        end
    end

    // N x 8 product fits in N+8 bits; the shifted accumulator never exceeds 2N bits.
    assign pp       = {8'b0, a_lat} * {{N{1'b0}}, b_byte};
    assign acc_next = (acc << 8) + AW'(pp);

`ifdef EARLY_TERM_EN
    logic [CW-1:0] msb_idx;

    // Ascending scan: the highest nonzero byte wins.
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (b[8*i +: 8] != 8'd0) msb_idx = CW'(i);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            acc   <= '0;
            cnt   <= '0;
            a_lat <= '0;
            b_lat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat <= a;
                        b_lat <= b;
                        acc   <= '0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
`ifdef EARLY_TERM_EN
                        if (b == '0) begin
                            cnt   <= '0;
                            p     <= '0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt   <= msb_idx;
                            state <= RUN;
                        end
`else
                        cnt   <= CW'(BYTES - 1);
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (cnt == '0) begin
                        p     <= acc_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_mult_ctrl.sv
// Bench for byte_serial_mult_ctrl: arithmetic reference model plus directed and random operations.
// Honors EARLY_TERM_EN for expected latency.
module tb_byte_serial_mult_ctrl;

    localparam int BYTES = 5;
    localparam int N     = 8 * BYTES;
    localparam int PW    = 2 * N;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          ready;
    logic          busy;
    logic          done;
    logic [PW-1:0] p;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [PW-1:0] exp_q[$];

    // Reference model state: phase 0 idle, 1 working, 2 done pulse.
    int            m_phase;
    int            m_rem;
    logic [PW-1:0] m_prod;
    logic [PW-1:0] m_p;

    byte_serial_mult_ctrl #(.BYTES(BYTES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iters(input logic [N-1:0] bb);
`ifdef EARLY_TERM_EN
        int k;
        k = 0;
        for (int i = 0; i < BYTES; i++) if (bb[8*i +: 8] != 8'd0) k = i + 1;
        return k;
`else
        return BYTES;
`endif
    endfunction

    function automatic logic [PW-1:0] mul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [PW-1:0] wx, wy;
        wx = PW'(x);
        wy = PW'(y);
        return wx * wy;
    endfunction

    // ---------------- reference model ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_rem   = 0;
            m_p     = '0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_prod = mul(a, b);
                    exp_q.push_back(m_prod);
                    m_rem = iters(b);
                    if (m_rem == 0) begin
                        m_phase = 2;
                        m_p     = m_prod;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_phase = 2;
                        m_p     = m_prod;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", PW'(ready), PW'(m_phase == 0));
            chk("busy",  PW'(busy),  PW'(m_phase != 0));
            chk("done",  PW'(done),  PW'(m_phase == 2));
            chk("p_hold", p, m_p);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", PW'(1), PW'(0));
                end else begin
                    chk("sb_p", p, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Latency counts edges from the accept edge (inclusive) to the first cycle done is seen.
    task automatic run_op(input logic [N-1:0] aa, input logic [N-1:0] bb,
                          input logic [PW-1:0] exp_p, input int exp_lat,
                          input bit rnd, input string name);
        int n;
        @(negedge clk);
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && n < 20) begin
            if (rnd) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (done !== 1'b1) chk({name, "_timeout"}, PW'(0), PW'(1));
        chk({name, "_lat"}, PW'(n), PW'(exp_lat));
        chk({name, "_p"}, p, exp_p);
    endtask

    task automatic held_start_test();
        int cyc, last, cnt_done;
        @(negedge clk);
        a        = 40'h12;
        b        = 40'h0100000000;
        start    = 1'b1;
        cyc      = 0;
        last     = -1;
        cnt_done = 0;
        while (cnt_done < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                chk("held_p", p, 80'h1200000000);
                if (last >= 0) chk("held_spacing", PW'(cyc - last), PW'(BYTES + 2));
                last = cyc;
                cnt_done++;
                if (cnt_done == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("held_count", PW'(cnt_done), PW'(3));
    endtask

    task automatic mid_reset_test();
        @(negedge clk);
        a     = 40'h55;
        b     = 40'hFFFFFFFFFF;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst   = 1'b1;
        start = 1'b1;
        #1;
        chk("rst_ready", PW'(ready), PW'(1));
        chk("rst_busy",  PW'(busy),  PW'(0));
        chk("rst_done",  PW'(done),  PW'(0));
        chk("rst_p",     p,          '0);
        @(posedge clk);
        #1;
        chk("rst_ignore_start", PW'(ready), PW'(1));
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N-1:0]  ra, rb, mask;
        int            nb;
        logic [PW-1:0] ep;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", PW'(ready), PW'(1));
        chk("reset_busy",  PW'(busy),  PW'(0));
        chk("reset_done",  PW'(done),  PW'(0));
        chk("reset_p",     p,          '0);
        rst    = 1'b0;
        chk_en = 1;

`ifdef EARLY_TERM_EN
        run_op(40'h3, 40'h5, 80'h0F, 2, 0, "small");
`else
        run_op(40'h3, 40'h5, 80'h0F, 6, 0, "small");
`endif
        run_op(40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 80'hFFFFFFFFFE0000000001, 6, 0, "max");
        held_start_test();
        repeat (2) @(negedge clk);
        mid_reset_test();
`ifdef EARLY_TERM_EN
        run_op(40'd7, 40'd9, 80'd63, 2, 0, "after_rst");
        run_op(40'h1234, 40'h5678, 80'h06260060, 3, 1, "rnd_inputs");
        run_op(40'hABCDEF, 40'h0, 80'h0, 1, 0, "b_zero");
`else
        run_op(40'd7, 40'd9, 80'd63, 6, 0, "after_rst");
        run_op(40'h1234, 40'h5678, 80'h06260060, 6, 1, "rnd_inputs");
        run_op(40'hABCDEF, 40'h0, 80'h0, 6, 0, "b_zero");
`endif

        for (int t = 0; t < 30; t++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            nb   = $urandom_range(0, BYTES);
            mask = '0;
            for (int i = 0; i < nb; i++) mask[8*i +: 8] = 8'hFF;
            rb = rb & mask;
            if ($urandom_range(0, 7) == 0) ra = '0;
            ep = mul(ra, rb);
            run_op(ra, rb, ep, iters(rb) + 1, t[0], "random");
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", PW'(exp_q.size()), PW'(0));
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
